fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/dlx_pkg.sv | 46 ++++
 rtl/next_pc_gen.sv | 50 +++++
 rtl/fetch_unit.sv | 132 +++++++++++++
 tb/tb_fetch_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/dlx_pkg.sv
// Shared DLX definitions: fetch FSM states, default reset PC, instruction field
// positions and the team 32-bit carry-lookahead adder.
package dlx_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 26;
    localparam int unsigned IMM16_MSB  = 15;
    localparam int unsigned IMM26_MSB  = 25;

    // Two-level lookahead: 4-bit groups, group carries chained through G/P terms.
    function automatic logic [31:0] cla_add32(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] g;
        logic [31:0] p;
        logic [31:0] c;
        logic [6:0]  gg;
        logic [6:0]  gp;
        logic [7:0]  gc;
        g     = a & b;
        p     = a ^ b;
        gc    = 8'h00;
        for (int k = 0; k < 7; k++) begin
            gg[k]   = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                    | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k]   = &p[4*k +: 4];
            gc[k+1] = gg[k] | (gp[k] & gc[k]);
        end
        for (int k = 0; k < 8; k++) begin
            c[4*k]   = gc[k];
            c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
        end
        return p ^ c;
    endfunction

endpackage

// File: rtl/next_pc_gen.sv
// Combinational next-PC generator: pc+4, sign-extended branch/jump offsets and
// the jmp_r > jmp > taken-branch > sequential priority select.
module next_pc_gen
    import dlx_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [25:0] imm26,
    input  logic        branch_z,
    input  logic        branch_nz,
    input  logic        jmp,
    input  logic        jmp_r,
    input  logic        zero,
    input  logic [31:0] bus_a,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc
);

    logic [31:0] offset_s;
    logic [31:0] target_s;
    logic        taken_s;

    assign pc_plus4 = cla_add32(pc, 32'd4);
    assign target_s = cla_add32(pc_plus4, offset_s);
    assign taken_s  = (branch_z & zero) | (branch_nz & ~zero);

    // Offset width follows the jump format when jmp is set, else the branch format.
    always_comb begin
        offset_s = 32'h0000_0000;
        if (jmp) begin
            offset_s = {{6{imm26[IMM26_MSB]}}, imm26[IMM26_MSB:0]};
        end else begin
            offset_s = {{16{imm26[IMM16_MSB]}}, imm26[IMM16_MSB:0]};
        end
    end

    // A branch raised alongside any jump loses to the jump.
    always_comb begin
        next_pc = pc_plus4;
        if (jmp_r) begin
            next_pc = bus_a;
        end else if (jmp) begin
            next_pc = target_s;
        end else if (taken_s) begin
            next_pc = target_s;
        end else begin
            next_pc = pc_plus4;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// DLX instruction fetch unit: BOOT/FETCH/ISSUE(/FAULT) FSM holding PC and IR.
// Optional PC_ALIGN_CHECK_EN traps misaligned redirects in FAULT instead of masking them.
module fetch_unit
    import dlx_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    input  logic        branch_z,
    input  logic        branch_nz,
    input  logic        jmp,
    input  logic        jmp_r,
    input  logic        zero,
    input  logic [31:0] bus_a,
    output logic        fault
);

    fetch_state_e state_r;
    fetch_state_e state_nx_s;
    logic [31:0]  pc_r;
    logic [31:0]  pc_nx_s;
    logic [31:0]  ir_r;
    logic [31:0]  ir_nx_s;
    logic [31:0]  next_pc_s;
    logic         imem_req_r;
    logic         inst_valid_r;

    next_pc_gen u_next_pc_gen (
        .pc        (pc_r),
        .imm26     (ir_r[IMM26_MSB:0]),
        .branch_z  (branch_z),
        .branch_nz (branch_nz),
        .jmp       (jmp),
        .jmp_r     (jmp_r),
        .zero      (zero),
        .bus_a     (bus_a),
        .pc_plus4  (pc_plus4),
        .next_pc   (next_pc_s)
    );

    // Next-state, PC and IR update; acks and retires outside their state fall through.
    always_comb begin
        state_nx_s = state_r;
        pc_nx_s    = pc_r;
        ir_nx_s    = ir_r;
        case (state_r)
            ST_BOOT: begin
                state_nx_s = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    ir_nx_s    = imem_rdata;
                    state_nx_s = ST_ISSUE;
                end else begin
                    state_nx_s = ST_FETCH;
                end
            end
            ST_ISSUE: begin
                if (inst_ready) begin
`ifdef PC_ALIGN_CHECK_EN
                    pc_nx_s = next_pc_s;
                    if (next_pc_s[1:0] != 2'b00) begin
                        state_nx_s = ST_FAULT;
                    end else begin
                        state_nx_s = ST_FETCH;
                    end
`else
                    pc_nx_s    = next_pc_s & 32'hFFFF_FFFC;
                    state_nx_s = ST_FETCH;
`endif
                end else begin
                    state_nx_s = ST_ISSUE;
                end
            end
            ST_FAULT: begin
                state_nx_s = ST_FAULT;
            end
            default: begin
                state_nx_s = ST_BOOT;
            end
        endcase
    end

`ifdef PC_ALIGN_CHECK_EN
    logic fault_r;
`endif

    // State, PC, IR and the output flags decoded one cycle early from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_BOOT;
            pc_r         <= RESET_PC;
            ir_r         <= 32'h0000_0000;
            imem_req_r   <= 1'b0;
            inst_valid_r <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            fault_r      <= 1'b0;
`endif
        end else begin
            state_r      <= state_nx_s;
            pc_r         <= pc_nx_s;
            ir_r         <= ir_nx_s;
            imem_req_r   <= (state_nx_s == ST_FETCH);
            inst_valid_r <= (state_nx_s == ST_ISSUE);
`ifdef PC_ALIGN_CHECK_EN
            fault_r      <= (state_nx_s == ST_FAULT);
`endif
        end
    end

    assign imem_req   = imem_req_r;
    assign imem_addr  = pc_r;
    assign inst       = ir_r;
    assign inst_valid = inst_valid_r;
    assign pc_out     = pc_r;
`ifdef PC_ALIGN_CHECK_EN
    assign fault      = fault_r;
`else
    assign fault      = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected fetch addresses and issued words are
// queued when stimulus is driven and compared when the unit requests/issues.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        branch_z = 1'b0;
    logic        branch_nz = 1'b0;
    logic        jmp = 1'b0;
    logic        jmp_r = 1'b0;
    logic        zero = 1'b0;
    logic [31:0] bus_a = 32'h0;
    logic        fault;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_inst_q[$];
    logic [31:0] exp_pc_q[$];
    logic [31:0] cur_inst = 32'h0;
    logic [31:0] cur_pc = 32'h0;

    fetch_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst       (inst),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .pc_out     (pc_out),
        .pc_plus4   (pc_plus4),
        .branch_z   (branch_z),
        .branch_nz  (branch_nz),
        .jmp        (jmp),
        .jmp_r      (jmp_r),
        .zero       (zero),
        .bus_a      (bus_a),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] ir,
                                               input logic bz, input logic bnz, input logic j,
                                               input logic jr, input logic z, input logic [31:0] a);
        logic [31:0] p4;
        p4 = pc + 32'd4;
        if (jr) return a;
        if (j) return p4 + {{6{ir[25]}}, ir[25:0]};
        if ((bz & z) | (bnz & ~z)) return p4 + {{16{ir[15]}}, ir[15:0]};
        return p4;
    endfunction

    task automatic do_fetch(input logic [31:0] rdata, input int wait_cycles);
        logic [31:0] exp_a;
        int n;
        n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("req_seen", {31'b0, imem_req}, 32'd1);
        check_eq("addr_q_depth", 32'(exp_addr_q.size()), 32'd1);
        exp_a = (exp_addr_q.size() > 0) ? exp_addr_q.pop_front() : 32'hFFFF_FFFF;
        check_eq("imem_addr", imem_addr, exp_a);
        for (int w = 0; w < wait_cycles; w++) begin
            @(negedge clk);
            check_eq("addr_stable", imem_addr, exp_a);
            check_eq("req_held", {31'b0, imem_req}, 32'd1);
        end
        imem_ack   = 1'b1;
        imem_rdata = rdata;
        exp_inst_q.push_back(rdata);
        exp_pc_q.push_back(exp_a);
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        cur_inst   = exp_inst_q.pop_front();
        cur_pc     = exp_pc_q.pop_front();
        check_eq("inst_valid", {31'b0, inst_valid}, 32'd1);
        check_eq("inst", inst, cur_inst);
        check_eq("pc_out", pc_out, cur_pc);
        check_eq("pc_plus4", pc_plus4, cur_pc + 32'd4);
        check_eq("req_off_issue", {31'b0, imem_req}, 32'd0);
        check_eq("fault_clear", {31'b0, fault}, 32'd0);
    endtask

    task automatic do_retire(input logic bz, input logic bnz, input logic j, input logic jr,
                             input logic z, input logic [31:0] a);
        logic [31:0] n;
        n = model_next(cur_pc, cur_inst, bz, bnz, j, jr, z, a);
`ifdef PC_ALIGN_CHECK_EN
        if (n[1:0] == 2'b00) exp_addr_q.push_back(n);
`else
        exp_addr_q.push_back({n[31:2], 2'b00});
`endif
        branch_z = bz; branch_nz = bnz; jmp = j; jmp_r = jr; zero = z; bus_a = a;
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        branch_z = 1'b0; branch_nz = 1'b0; jmp = 1'b0; jmp_r = 1'b0; zero = 1'b0;
        bus_a = $urandom;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req"}, {31'b0, imem_req}, 32'd0);
        check_eq({tag, "_valid"}, {31'b0, inst_valid}, 32'd0);
        check_eq({tag, "_fault"}, {31'b0, fault}, 32'd0);
        check_eq({tag, "_inst"}, inst, 32'h0);
        check_eq({tag, "_pc"}, pc_out, 32'h0);
        check_eq({tag, "_pc4"}, pc_plus4, 32'h4);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        exp_addr_q.push_back(32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        do_fetch(32'h2001_0005, 0);
        do_retire(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100);
        do_fetch(32'h1000_FFF8, 0);
        do_retire(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);      // taken back to 0x0FC
        do_fetch(32'h0000_0000, 2);
        do_retire(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100);
        do_fetch(32'h1000_FFF8, 0);
        do_retire(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);      // not taken -> 0x104
        do_fetch(32'h0000_0001, 0);
        do_retire(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h200);
        do_fetch(32'h0800_0010, 0);
        do_retire(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);      // jmp beats branch -> 0x214
        do_fetch(32'h0BFF_FFFF, 0);
        do_retire(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h400);    // jmp_r beats jmp
        do_fetch(32'h1400_0004, 0);

        for (int i = 0; i < 5; i++) begin
            imem_ack   = ~imem_ack;
            imem_rdata = $urandom;
            @(negedge clk);
            check_eq("bp_inst", inst, cur_inst);
            check_eq("bp_pc", pc_out, cur_pc);
            check_eq("bp_req", {31'b0, imem_req}, 32'd0);
            check_eq("bp_valid", {31'b0, inst_valid}, 32'd1);
        end
        imem_ack = 1'b0;

        do_retire(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0);      // bnz with zero=1 -> 0x404
        do_fetch(32'h0000_0002, 0);
        do_retire(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC);
        do_fetch(32'h0000_0003, 0);
        do_retire(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);      // wraps to 0
        do_fetch(32'h0000_0004, 1);
        do_retire(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h80);

        // Reset mid-FETCH at 0x80 with a stale ack landing in BOOT.
        check_eq("pre_rst_req", {31'b0, imem_req}, 32'd1);
        check_eq("pre_rst_addr", imem_addr, exp_addr_q.size() > 0 ? exp_addr_q.pop_front() : 32'hFFFF_FFFF);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        @(negedge clk);
        rst_n      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        imem_ack = 1'b0;
        check_eq("stale_ack_inst", inst, 32'h0);
        check_eq("stale_ack_valid", {31'b0, inst_valid}, 32'd0);
        exp_addr_q.push_back(32'h0);
        do_fetch(32'h0000_0005, 0);

        do_retire(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h402);
`ifdef PC_ALIGN_CHECK_EN
        for (int i = 0; i < 4; i++) begin
            check_eq("flt_fault", {31'b0, fault}, 32'd1);
            check_eq("flt_req", {31'b0, imem_req}, 32'd0);
            check_eq("flt_valid", {31'b0, inst_valid}, 32'd0);
            check_eq("flt_pc", pc_out, 32'h402);
            imem_ack   = 1'b1;
            inst_ready = 1'b1;
            @(negedge clk);
        end
        imem_ack   = 1'b0;
        inst_ready = 1'b0;
`else
        do_fetch(32'h0000_0006, 0);
        check_eq("noflt_pc", pc_out, 32'h400);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
